// File: rtl/jellyvl_synctimer_slew_timer.sv
// Synchronised timer advancing NUMERATOR/DENOMINATOR units per clock, with
// bounded-rate signed phase slewing that never lets current_time run backwards.
module jellyvl_synctimer_slew_timer #(
  parameter int TIMER_WIDTH = 64,
  parameter int NUMERATOR   = 10,
  parameter int DENOMINATOR = 3,
  parameter int SLEW_WIDTH  = 32,
  parameter int STEP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   slew_sign,
  input  logic [SLEW_WIDTH-1:0]  slew_amount,
  input  logic                   slew_valid,
  output logic                   slew_ready,
  input  logic [STEP_WIDTH-1:0]  slew_step,
  output logic                   slew_busy,
  output logic [SLEW_WIDTH-1:0]  slew_remaining,
  output logic                   slew_done,
  output logic [TIMER_WIDTH-1:0] current_time
);
  localparam int Q  = NUMERATOR / DENOMINATOR;
  localparam int R  = NUMERATOR % DENOMINATOR;
  // one spare bit so frac + R (at most 2*DENOMINATOR-2) never overflows
  localparam int FW = $clog2(DENOMINATOR) + 1;
  localparam logic [FW-1:0]          R_F   = FW'(R);
  localparam logic [FW-1:0]          DEN_F = FW'(DENOMINATOR);
  localparam logic [SLEW_WIDTH-1:0]  Q_S   = SLEW_WIDTH'(Q);
  localparam logic [TIMER_WIDTH-1:0] Q_T   = TIMER_WIDTH'(Q);

  logic [FW-1:0]          frac, frac_sum, frac_next;
  logic                   carry;
  logic                   sign_r, zero_pend;
  logic [SLEW_WIDTH-1:0]  step_ext, stp, applied;
  logic [TIMER_WIDTH-1:0] inc, time_next;

  assign slew_ready = !slew_busy && !set_valid;

  always_comb begin
    frac_sum  = frac + R_F;
    carry     = (frac_sum >= DEN_F);
    frac_next = carry ? (frac_sum - DEN_F) : frac_sum;
    inc       = Q_T + TIMER_WIDTH'(carry);

    step_ext = SLEW_WIDTH'(slew_step);
    stp      = (step_ext == '0) ? SLEW_WIDTH'(1) : step_ext;
    // retarding by at most Q keeps the per-clock delta >= carry >= 0
    if (sign_r && (stp > Q_S)) stp = Q_S;
    applied = '0;
    if (slew_busy) applied = (stp < slew_remaining) ? stp : slew_remaining;

    time_next = sign_r ? (current_time + inc - TIMER_WIDTH'(applied))
                       : (current_time + inc + TIMER_WIDTH'(applied));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_time   <= '0;
      frac           <= '0;
      slew_busy      <= 1'b0;
      slew_remaining <= '0;
      slew_done      <= 1'b0;
      sign_r         <= 1'b0;
      zero_pend      <= 1'b0;
    end else if (set_valid) begin
      current_time   <= set_time;
      frac           <= '0;
      slew_busy      <= 1'b0;
      slew_remaining <= '0;
      slew_done      <= 1'b0;
      zero_pend      <= 1'b0;
    end else begin
      current_time <= time_next;
      frac         <= frac_next;
      slew_done    <= 1'b0;
      if (slew_busy) begin
        slew_remaining <= slew_remaining - applied;
        if (slew_remaining == applied) begin
          slew_busy <= 1'b0;
          slew_done <= 1'b1;
        end
      end
      // a zero-length slew completes one edge after acceptance
      if (zero_pend) begin
        slew_done <= 1'b1;
        zero_pend <= 1'b0;
      end
      if (slew_valid && slew_ready) begin
        sign_r <= slew_sign;
        if (slew_amount == '0) begin
          zero_pend <= 1'b1;
        end else begin
          slew_remaining <= slew_amount;
          slew_busy      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jellyvl_synctimer_slew_timer.sv
// Bench for the slew timer: directed vector table, hand sequences for rate and
// reset corners, and a randomized run against a closed-form reference model.
module tb_jellyvl_synctimer_slew_timer;
  localparam int NUM = 10;
  localparam int DEN = 3;
  localparam int Q   = NUM / DEN;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] set_time;
  logic        set_valid;
  logic        slew_sign;
  logic [31:0] slew_amount;
  logic        slew_valid;
  logic        slew_ready;
  logic [7:0]  slew_step;
  logic        slew_busy;
  logic [31:0] slew_remaining;
  logic        slew_done;
  logic [63:0] current_time;

  jellyvl_synctimer_slew_timer dut (
    .clk(clk), .reset(reset), .set_time(set_time), .set_valid(set_valid),
    .slew_sign(slew_sign), .slew_amount(slew_amount), .slew_valid(slew_valid),
    .slew_ready(slew_ready), .slew_step(slew_step), .slew_busy(slew_busy),
    .slew_remaining(slew_remaining), .slew_done(slew_done), .current_time(current_time)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: nominal time is floor(n*NUM/DEN) since the last set/reset,
  // plus the signed total of slew units applied so far.
  logic [63:0] m_base, m_sacc;
  int          m_n;
  logic [31:0] m_rem;
  logic        m_sgn, m_busy, m_done, m_zp;

  task automatic model_reset();
    m_base = '0; m_sacc = '0; m_n = 0; m_rem = '0;
    m_sgn = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_zp = 1'b0;
  endtask

  function automatic logic [63:0] m_time();
    return m_base + 64'(longint'(m_n) * NUM / DEN) + m_sacc;
  endfunction

  task automatic model_edge();
    logic [31:0] stp, a;
    logic dn, rdy;
    rdy = !m_busy && !set_valid;
    if (set_valid) begin
      m_base = set_time; m_n = 0; m_sacc = '0; m_rem = '0;
      m_busy = 1'b0; m_done = 1'b0; m_zp = 1'b0;
    end else begin
      m_n++;
      dn = 1'b0;
      if (m_busy) begin
        stp = (slew_step == 8'd0) ? 32'd1 : 32'(slew_step);
        if (m_sgn && stp > Q) stp = Q;
        a = (stp < m_rem) ? stp : m_rem;
        m_sacc = m_sgn ? m_sacc - 64'(a) : m_sacc + 64'(a);
        m_rem = m_rem - a;
        if (m_rem == 0) begin m_busy = 1'b0; dn = 1'b1; end
      end
      if (m_zp) begin dn = 1'b1; m_zp = 1'b0; end
      if (slew_valid && rdy) begin
        m_sgn = slew_sign;
        if (slew_amount == 0) m_zp = 1'b1;
        else begin m_rem = slew_amount; m_busy = 1'b1; end
      end
      m_done = dn;
    end
  endtask

  task automatic idle_inputs();
    set_valid = 1'b0; set_time = '0; slew_valid = 1'b0;
    slew_amount = '0; slew_sign = 1'b0; slew_step = 8'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sv;
    logic [63:0] st;
    logic        lv;
    logic [31:0] amt;
    logic        sgn;
    logic [7:0]  step;
    logic        e_ready;
    logic [63:0] e_time;
    logic        e_busy;
    logic [31:0] e_rem;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic sv, input logic [63:0] st, input logic lv, input logic [31:0] amt,
                     input logic sgn, input logic [7:0] step, input logic e_ready,
                     input logic [63:0] e_time, input logic e_busy, input logic [31:0] e_rem,
                     input logic e_done);
    vec_t v;
    v.sv = sv; v.st = st; v.lv = lv; v.amt = amt; v.sgn = sgn; v.step = step;
    v.e_ready = e_ready; v.e_time = e_time; v.e_busy = e_busy; v.e_rem = e_rem; v.e_done = e_done;
    tbl.push_back(v);
  endtask

  initial begin
    logic [63:0] prev;
    // Directed table from reset: advance, retard clamp, set+wrap, zero amount, abort.
    add(0, 0, 1, 5,   0, 2, 1, 64'd3,  1, 5,   0);
    add(0, 0, 0, 0,   0, 2, 0, 64'd8,  1, 3,   0);
    add(0, 0, 0, 0,   0, 2, 0, 64'd14, 1, 1,   0);
    add(0, 0, 0, 0,   0, 2, 0, 64'd18, 0, 0,   1);
    add(0, 0, 0, 0,   0, 2, 1, 64'd21, 0, 0,   0);
    add(0, 0, 1, 7,   1, 8, 1, 64'd25, 1, 7,   0);
    add(0, 0, 0, 0,   1, 8, 0, 64'd25, 1, 4,   0);
    add(0, 0, 0, 0,   1, 8, 0, 64'd25, 1, 1,   0);
    add(0, 0, 0, 0,   1, 8, 0, 64'd28, 0, 0,   1);
    add(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 3, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 1, 64'd1,  0, 0,   0);
    add(0, 0, 0, 0,   0, 0, 1, 64'd4,  0, 0,   0);
    add(0, 0, 0, 0,   0, 0, 1, 64'd8,  0, 0,   0);
    add(0, 0, 1, 0,   0, 0, 1, 64'd11, 0, 0,   0);
    add(0, 0, 0, 0,   0, 0, 1, 64'd14, 0, 0,   1);
    add(0, 0, 0, 0,   0, 0, 1, 64'd18, 0, 0,   0);
    add(0, 0, 1, 100, 0, 0, 1, 64'd21, 1, 100, 0);
    add(0, 0, 0, 0,   0, 0, 0, 64'd25, 1, 99,  0);
    add(0, 0, 1, 5,   0, 0, 0, 64'd30, 1, 98,  0);
    add(1, 64'd1000, 0, 0, 0, 0, 0, 64'd1000, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 1, 64'd1003, 0, 0, 0);

    idle_inputs();
    reset = 1'b1;
    #10;
    chk("reset_time", current_time, 0);
    chk("reset_busy", slew_busy, 0);
    chk("reset_rem",  slew_remaining, 0);
    chk("reset_done", slew_done, 0);
    #2 reset = 1'b0;

    foreach (tbl[i]) begin
      set_valid = tbl[i].sv; set_time = tbl[i].st; slew_valid = tbl[i].lv;
      slew_amount = tbl[i].amt; slew_sign = tbl[i].sgn; slew_step = tbl[i].step;
      #2;
      chk($sformatf("tbl%0d_ready", i), slew_ready, tbl[i].e_ready);
      tick();
      chk($sformatf("tbl%0d_time", i), current_time, tbl[i].e_time);
      chk($sformatf("tbl%0d_busy", i), slew_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_rem", i),  slew_remaining, tbl[i].e_rem);
      chk($sformatf("tbl%0d_done", i), slew_done, tbl[i].e_done);
    end
    idle_inputs();

    // Rate: deltas 3,3,4 from reset, 10 after 3 clocks, 1000 after 300.
    reset = 1'b1; #3 reset = 1'b0;
    prev = current_time;
    chk("rate_start", prev, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rate_delta%0d", k), current_time - prev, (k == 2) ? 64'd4 : 64'd3);
      prev = current_time;
    end
    chk("rate_3clk", current_time, 64'd10);
    repeat (297) tick();
    chk("rate_300clk", current_time, 64'd1000);

    // Asynchronous reset in the middle of a slew.
    slew_valid = 1'b1; slew_amount = 32'd50; slew_step = 8'd1;
    tick();
    slew_valid = 1'b0;
    repeat (3) tick();
    chk("midslew_busy_before", slew_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midslew_reset_time", current_time, 0);
    chk("midslew_reset_busy", slew_busy, 0);
    chk("midslew_reset_rem",  slew_remaining, 0);
    chk("midslew_reset_done", slew_done, 0);
    idle_inputs();
    #3 reset = 1'b0;
    model_reset();

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      set_valid = ($urandom_range(0, 63) == 0);
      set_time  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                              : 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      slew_valid  = ($urandom_range(0, 3) == 0);
      slew_amount = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      slew_sign   = 1'($urandom_range(0, 1));
      slew_step   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      #2;
      chk("rnd_ready", slew_ready, !m_busy && !set_valid);
      model_edge();
      tick();
      chk("rnd_time", current_time, m_time());
      chk("rnd_busy", slew_busy, m_busy);
      chk("rnd_rem",  slew_remaining, m_rem);
      chk("rnd_done", slew_done, m_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
